gripper_sequencer: RTL and testbench
====================================

# gripper_sequencer

Command-driven sequencer for the robot dog's gripper servo. It accepts GRAB/RELEASE/HOME commands through a valid/ready handshake. It slews the servo pulse width toward the commanded position by at most one step per 20 ms PWM frame, and holds a settle interval before reporting completion. It gates RELEASE on the locomotion controller being idle, and generates the servo PWM itself. It sits between the top-level command FSM and the gripper servo pin.

## Interface
- FRAME_CYC, 1_000_000: clk cycles per PWM frame (20 ms @ 50 MHz).
- OPEN_W, 25_000: pulse width in cycles, gripper open (0.5 ms).
- CLOSED_W, 75_000: pulse width in cycles, gripper closed (1.5 ms).
- HOME_W, 50_000: pulse width in cycles, home/neutral (1.0 ms).
- STEP_W, 2_500: maximum change in pulse width per frame.
- SETTLE_FRAMES, 10: frames to hold after reaching target before done.
- W, 20: width of counters and pulse widths. It must satisfy FRAME_CYC < 2^W.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  block can accept a command.
- cmd_op  in  2  0 NOP, 1 GRAB, 2 RELEASE, 3 HOME.
- robot_idle  in  1  locomotion FSM is in its no-command state.
- pwm_out  out  1  servo PWM.
- cur_w  out  W  pulse width in use for the current frame.
- busy  out  1  command in progress (state ≠ IDLE).
- done  out  1  one-cycle pulse when a command completes.
- gripped  out  1  state is IDLE and cur_w == CLOSED_W.

## Operation
- States: IDLE, WAIT_IDLE, RAMP, SETTLE.
- **IDLE**
  - cmd_ready = 1. A transfer occurs on cmd_valid & cmd_ready.
  - NOP: done pulses the next cycle; no state change.
  - GRAB: target = CLOSED_W. HOME: target = HOME_W.
  - RELEASE: target = OPEN_W. Go to WAIT_IDLE if robot_idle = 0, otherwise proceed as below.
  - If target == cur_w: go to SETTLE. Otherwise go to RAMP.
- **WAIT_IDLE**
  - Hold until robot_idle = 1, then go to RAMP, or to SETTLE if target == cur_w.
  - robot_idle is sampled every cycle; no frame alignment is needed.
- **RAMP**
  - On each frame_tick: cur_w moves toward target by min(STEP_W, |target − cur_w|).
  - When the updated value equals target: go to SETTLE with settle_cnt = 0.
  - No overshoot. Compare in W+1 bits so no wrap is possible.
- **SETTLE**
  - settle_cnt increments on each frame_tick.
  - When it reaches SETTLE_FRAMES: go to IDLE and pulse done in the same cycle.
  - If SETTLE_FRAMES = 0: exit on entry.
- cmd_ready = 0 outside IDLE. Commands offered while busy are neither accepted nor dropped; the requester holds cmd_valid.
- cur_w changes only on frame_tick, so each frame's pulse is glitch-free.

## Timing
- frame_cnt runs 0..FRAME_CYC−1 and wraps. frame_tick = (frame_cnt == FRAME_CYC−1).
- pwm_out is registered: pwm_out <= (frame_cnt < cur_w). The output lags frame_cnt by one cycle.
- Each frame is high for exactly cur_w cycles and low for FRAME_CYC − cur_w cycles.
- A cur_w update on frame_tick takes effect in the frame starting on the next cycle.
- Reset values: frame_cnt = 0, cur_w = OPEN_W, pwm_out = 0, state = IDLE, settle_cnt = 0, done = 0, busy = 0, gripped = 0, cmd_ready = 1.
- Reset asserted mid-ramp: everything returns to reset values on the next edge and the target is discarded.
- Command accepted in the same cycle as frame_tick:
  - The transition to RAMP happens that cycle.
  - The first step occurs on the next frame_tick, not this one.
- Ramp latency: ceil(|Δ|/STEP_W) frames.
- done follows the last ramp step by SETTLE_FRAMES frames, or fires directly from WAIT_IDLE/IDLE when there is no motion and SETTLE_FRAMES = 0.
- robot_idle falling during RAMP/SETTLE is ignored. It gates only the start of a RELEASE.

## Structure
- Package gripper_pkg holds:
  - op encodings: OP_NOP, OP_GRAB, OP_RELEASE, OP_HOME.
  - the state enum.
- Sub-module servo_pwm_frame (parameter FRAME_CYC, W):
  - Owns frame_cnt, frame_tick, and the registered comparator producing pwm_out from cur_w.
  - The sequencer owns the FSM, cur_w, target and settle_cnt.

## Test plan
Sim parameters for all scenarios: FRAME_CYC=100, OPEN_W=10, CLOSED_W=30, HOME_W=20, STEP_W=4, SETTLE_FRAMES=2.
- **Reset:** hold rst_n = 0 for 3 cycles.
  - After release: pwm_out is high exactly 10 cycles per 100.
  - cmd_ready = 1, busy = 0, gripped = 0.
- **GRAB from open:**
  - Successive frame high times are 10, 14, 18, 22, 26, 30, 30, 30.
  - done pulses once, 2 frames after width 30 is first applied; gripped = 1 afterwards.
- **RELEASE with robot_idle = 0 for 350 cycles:**
  - State is WAIT_IDLE and cur_w stays 30 throughout.
  - After robot_idle rises: ramp 30→26→…→10, then done.
- **HOME from open:** widths step 10→14→18→20, with a 2-cycle final step and no overshoot.
- **cmd_valid held during RAMP:** no accept while busy; the command is accepted on the cycle after done.
- **rst_n pulsed mid-GRAB at cur_w = 22:** cur_w = 10 and state = IDLE on the next edge; done never pulses.

Source files
------------

// File: rtl/gripper_pkg.sv
// Shared encodings for the gripper servo sequencer: command opcodes and FSM states.
package gripper_pkg;

   typedef enum logic [1:0] {
      OP_NOP     = 2'd0,
      OP_GRAB    = 2'd1,
      OP_RELEASE = 2'd2,
      OP_HOME    = 2'd3
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT_IDLE,
      ST_RAMP,
      ST_SETTLE
   } state_e;

endpackage

// File: rtl/gripper_sequencer_if.sv
// Command handshake between the top-level command FSM and the gripper sequencer.
interface gripper_sequencer_if
   import gripper_pkg::*;
   ();

   logic cmd_valid;
   logic cmd_ready;
   op_e  cmd_op;

   modport master (output cmd_valid, output cmd_op, input cmd_ready);
   modport slave  (input cmd_valid, input cmd_op, output cmd_ready);

endinterface

// File: rtl/servo_pwm_frame.sv
// Free-running PWM frame counter with a registered width comparator for the servo pin.
module servo_pwm_frame #(
   parameter int unsigned FRAME_CYC = 1_000_000,
   parameter int unsigned W         = 20
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] cur_w,
   output logic         frame_tick,
   output logic         pwm_out
);

   logic [W-1:0] frame_cnt;

   assign frame_tick = (frame_cnt == W'(FRAME_CYC - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         frame_cnt <= '0;
         pwm_out   <= 1'b0;
      end else begin
         frame_cnt <= frame_tick ? '0 : frame_cnt + 1'b1;
         pwm_out   <= (frame_cnt < cur_w);
      end
   end

endmodule

// File: rtl/gripper_sequencer.sv
// Gripper servo sequencer: accepts GRAB/RELEASE/HOME, slews the pulse width one
// bounded step per PWM frame, settles for a number of frames and then reports done.
module gripper_sequencer
   import gripper_pkg::*;
#(
   parameter int unsigned FRAME_CYC     = 1_000_000,
   parameter int unsigned OPEN_W        = 25_000,
   parameter int unsigned CLOSED_W      = 75_000,
   parameter int unsigned HOME_W        = 50_000,
   parameter int unsigned STEP_W        = 2_500,
   parameter int unsigned SETTLE_FRAMES = 10,
   parameter int unsigned W             = 20
) (
   input  logic                clk,
   input  logic                rst_n,
   gripper_sequencer_if.slave  cmd,
   input  logic                robot_idle,
   output logic                pwm_out,
   output logic [W-1:0]        cur_w,
   output logic                busy,
   output logic                done,
   output logic                gripped
);

   localparam int unsigned SC_W = $clog2(SETTLE_FRAMES + 2);
   localparam logic [W-1:0] OPEN_V   = W'(OPEN_W);
   localparam logic [W-1:0] CLOSED_V = W'(CLOSED_W);
   localparam logic [W-1:0] HOME_V   = W'(HOME_W);
   localparam logic [W:0]   STEP_X   = (W+1)'(STEP_W);
   localparam logic [SC_W-1:0] SETTLE_V = SC_W'(SETTLE_FRAMES);

   state_e          state, state_nx;
   logic [W-1:0]    cur_nx, target, target_nx, req_w;
   logic [SC_W-1:0] settle_cnt, settle_nx;
   logic            nop_done, nop_done_nx;
   logic            settle_exit;
   logic            frame_tick;
   logic [W:0]      cur_x, tgt_x, diff, stepped;
   logic            up;

   servo_pwm_frame #(
      .FRAME_CYC (FRAME_CYC),
      .W         (W)
   ) u_pwm (
      .clk        (clk),
      .rst_n      (rst_n),
      .cur_w      (cur_w),
      .frame_tick (frame_tick),
      .pwm_out    (pwm_out)
   );

   // Step arithmetic in W+1 bits; the subtract branch only runs when cur_w exceeds target by more than a step.
   always_comb begin
      cur_x   = {1'b0, cur_w};
      tgt_x   = {1'b0, target};
      up      = (tgt_x > cur_x);
      diff    = up ? (tgt_x - cur_x) : (cur_x - tgt_x);
      stepped = tgt_x;
      if (diff > STEP_X) begin
         stepped = up ? (cur_x + STEP_X) : (cur_x - STEP_X);
      end
   end

   always_comb begin
      req_w = cur_w;
      case (cmd.cmd_op)
         OP_GRAB:    req_w = CLOSED_V;
         OP_RELEASE: req_w = OPEN_V;
         OP_HOME:    req_w = HOME_V;
         default:    req_w = cur_w;
      endcase
   end

   always_comb begin
      state_nx    = state;
      cur_nx      = cur_w;
      target_nx   = target;
      settle_nx   = settle_cnt;
      nop_done_nx = 1'b0;
      settle_exit = 1'b0;
      case (state)
         ST_IDLE: begin
            if (cmd.cmd_valid) begin
               if (cmd.cmd_op == OP_NOP) begin
                  nop_done_nx = 1'b1;
               end else begin
                  target_nx = req_w;
                  settle_nx = '0;
                  if (cmd.cmd_op == OP_RELEASE && !robot_idle) begin
                     state_nx = ST_WAIT_IDLE;
                  end else if (req_w == cur_w) begin
                     state_nx = ST_SETTLE;
                  end else begin
                     state_nx = ST_RAMP;
                  end
               end
            end
         end
         ST_WAIT_IDLE: begin
            if (robot_idle) begin
               state_nx = (target == cur_w) ? ST_SETTLE : ST_RAMP;
            end
         end
         ST_RAMP: begin
            if (frame_tick) begin
               cur_nx = stepped[W-1:0];
               if (stepped == tgt_x) begin
                  state_nx  = ST_SETTLE;
                  settle_nx = '0;
               end
            end
         end
         ST_SETTLE: begin
            if (settle_cnt == SETTLE_V) begin
               state_nx    = ST_IDLE;
               settle_nx   = '0;
               settle_exit = 1'b1;
            end else if (frame_tick) begin
               settle_nx = settle_cnt + 1'b1;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         cur_w      <= OPEN_V;
         target     <= OPEN_V;
         settle_cnt <= '0;
         nop_done   <= 1'b0;
      end else begin
         state      <= state_nx;
         cur_w      <= cur_nx;
         target     <= target_nx;
         settle_cnt <= settle_nx;
         nop_done   <= nop_done_nx;
      end
   end

   assign cmd.cmd_ready = (state == ST_IDLE);
   assign busy          = (state != ST_IDLE);
   assign done          = nop_done | settle_exit;
   assign gripped       = (state == ST_IDLE) && (cur_w == CLOSED_V);

endmodule

// File: tb/tb_gripper_sequencer.sv
// Randomized directed bench for gripper_sequencer; measured PWM pulses and done timing are
// compared against a frame-arithmetic model of the slew/settle rules.
module tb_gripper_sequencer;
   import gripper_pkg::*;

   localparam int FC = 100;
   localparam int OW = 10;
   localparam int CW = 30;
   localparam int HW = 20;
   localparam int SW = 4;
   localparam int SF = 2;
   localparam int WW = 20;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          robot_idle = 1'b0;
   logic          pwm_out, busy, done, gripped;
   logic [WW-1:0] cur_w;

   gripper_sequencer_if cmd_if ();

   gripper_sequencer #(
      .FRAME_CYC     (FC),
      .OPEN_W        (OW),
      .CLOSED_W      (CW),
      .HOME_W        (HW),
      .STEP_W        (SW),
      .SETTLE_FRAMES (SF),
      .W             (WW)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cmd        (cmd_if),
      .robot_idle (robot_idle),
      .pwm_out    (pwm_out),
      .cur_w      (cur_w),
      .busy       (busy),
      .done       (done),
      .gripped    (gripped)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {int rise; int width;} pulse_t;
   pulse_t pulses[$];
   bit     in_p = 1'b0;
   int     p_rise, p_hi;
   int     done_count = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         in_p = 1'b0;
      end else begin
         if (pwm_out && !in_p) begin
            in_p = 1'b1; p_rise = cyc; p_hi = 1;
         end else if (pwm_out) begin
            p_hi++;
         end else if (in_p) begin
            in_p = 1'b0;
            pulses.push_back('{p_rise, p_hi});
         end
         if (done) done_count++;
      end
   end

   int vectors = 0, miscompares = 0;
   int base = 0, m_cur = OW;
   int acc_cyc, a_edge, s_edge, last_done = -1000;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   function automatic bit is_tick(int e);
      return (e >= base) && (((e - base) % FC) == FC - 1);
   endfunction

   function automatic int ticks_in(int lo, int hi);
      int n = 0;
      for (int e = lo + 1; e < hi; e++) if (is_tick(e)) n++;
      return n;
   endfunction

   function automatic int nth_tick(int s, int n);
      int e = s, c = 0;
      while (c < n) begin
         e++;
         if (is_tick(e)) c++;
      end
      return e;
   endfunction

   function automatic int tgt_of(op_e op);
      case (op)
         OP_GRAB:    return CW;
         OP_RELEASE: return OW;
         OP_HOME:    return HW;
         default:    return m_cur;
      endcase
   endfunction

   function automatic int width_after(int from, int to, int k);
      int w;
      if (to >= from) begin
         w = from + SW * k;
         return (w > to) ? to : w;
      end
      w = from - SW * k;
      return (w < to) ? to : w;
   endfunction

   function automatic int n_steps(int from, int to);
      int d = (to > from) ? to - from : from - to;
      return (d + SW - 1) / SW;
   endfunction

   task automatic check_pulses(input string tag, input int a, input int s,
                               input int from, input int to, input int upper);
      pulse_t keep[$];
      pulse_t p;
      while (pulses.size() > 0) begin
         p = pulses.pop_front();
         if (p.rise <= a) continue;
         if (p.rise > upper) keep.push_back(p);
         else chk(tag, p.width, width_after(from, to, ticks_in(s, p.rise)));
      end
      pulses = keep;
   endtask

   task automatic send(input op_e op, input int idle_lo, input bit hold, input op_e nxt);
      int guard = 0;
      cmd_if.cmd_op    = op;
      cmd_if.cmd_valid = 1'b1;
      if (op == OP_RELEASE) robot_idle = (idle_lo == 0);
      else robot_idle = 1'($urandom_range(0, 1));
      while (cmd_if.cmd_ready !== 1'b1 && guard < 5000) begin
         step();
         guard++;
      end
      chk("accept_wait", guard < 5000, 1);
      acc_cyc = cyc;
      a_edge  = cyc + 1;
      s_edge  = a_edge;
      step();
      if (hold) cmd_if.cmd_op = nxt;
      else cmd_if.cmd_valid = 1'b0;
      if (op == OP_RELEASE && idle_lo > 0) begin
         for (int i = 0; i < idle_lo; i++) begin
            chk("wait_idle_busy", busy, 1);
            chk("wait_idle_cur_w", cur_w, m_cur);
            step();
         end
         chk("wait_idle_state", dut.state, ST_WAIT_IDLE);
         robot_idle = 1'b1;
         s_edge = cyc + 1;
         step();
      end
      robot_idle = hold ? 1'b1 : 1'($urandom_range(0, 1));
   endtask

   task automatic finish(input string tag, input op_e op, input bit hold);
      int tgt, n, exp_done, dc, guard = 0;
      if (op == OP_NOP) begin
         chk("nop_done", done, 1);
         chk("nop_busy", busy, 0);
         step();
         chk("nop_done_width", done, 0);
         return;
      end
      tgt = tgt_of(op);
      n = n_steps(m_cur, tgt);
      exp_done = nth_tick(s_edge, n + SF);
      while (done !== 1'b1 && guard < 3000) begin
         step();
         guard++;
      end
      dc = cyc;
      chk({tag, "_done_cycle"}, dc, exp_done);
      last_done = dc;
      step();
      chk({tag, "_done_pulse"}, done, 0);
      chk({tag, "_gripped"}, gripped, tgt == CW);
      chk({tag, "_cur_w"}, cur_w, tgt);
      if (!hold) repeat (2 * FC + 10) step();
      check_pulses({tag, "_width"}, a_edge, s_edge, m_cur, tgt, hold ? dc : cyc);
      m_cur = tgt;
   endtask

   initial begin
      pulse_t p0, p1;
      op_e op;
      int idle_lo, guard, dc0;

      cmd_if.cmd_valid = 1'b0;
      cmd_if.cmd_op    = OP_NOP;

      // Reset and idle output
      repeat (3) step();
      chk("rst_ready", cmd_if.cmd_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_gripped", gripped, 0);
      chk("rst_done", done, 0);
      chk("rst_cur_w", cur_w, OW);
      chk("rst_pwm", pwm_out, 0);
      rst_n = 1'b1;
      base = cyc + 1;
      repeat (250) step();
      p0 = pulses[0];
      p1 = pulses[1];
      chk("frame_period", p1.rise - p0.rise, FC);
      chk("first_rise", p0.rise, base);
      check_pulses("reset_width", 0, 0, OW, OW, cyc);

      // Directed scenarios
      send(OP_GRAB, 0, 1'b0, OP_NOP);    finish("grab", OP_GRAB, 1'b0);
      send(OP_RELEASE, 350, 1'b0, OP_NOP); finish("release_wait", OP_RELEASE, 1'b0);
      send(OP_HOME, 0, 1'b0, OP_NOP);    finish("home", OP_HOME, 1'b0);
      send(OP_GRAB, 0, 1'b1, OP_RELEASE); finish("held_grab", OP_GRAB, 1'b1);
      send(OP_RELEASE, 0, 1'b0, OP_NOP);
      chk("held_accept_cycle", acc_cyc, last_done + 1);
      finish("held_release", OP_RELEASE, 1'b0);

      // Accept exactly on a frame_tick edge
      guard = 0;
      while (((cyc + 1 - base) % FC) != FC - 1 && guard < 500) begin
         step();
         guard++;
      end
      send(OP_GRAB, 0, 1'b0, OP_NOP);
      chk("tick_accept_edge", is_tick(a_edge), 1);
      finish("tick_grab", OP_GRAB, 1'b0);

      // Randomized command stream
      for (int i = 0; i < 10; i++) begin
         repeat ($urandom_range(0, 120)) step();
         op = op_e'($urandom_range(0, 3));
         idle_lo = (op == OP_RELEASE && $urandom_range(0, 1) == 1) ? int'($urandom_range(1, 300)) : 0;
         send(op, idle_lo, 1'b0, OP_NOP);
         finish("rand", op, 1'b0);
      end

      // Reset pulsed mid-GRAB
      send(OP_RELEASE, 0, 1'b0, OP_NOP); finish("pre_reset_release", OP_RELEASE, 1'b0);
      send(OP_GRAB, 0, 1'b0, OP_NOP);
      guard = 0;
      while (cur_w !== 22 && guard < 2000) begin
         step();
         guard++;
      end
      chk("reach_22", cur_w, 22);
      rst_n = 1'b0;
      step();
      chk("midrst_cur_w", cur_w, OW);
      chk("midrst_state", dut.state, ST_IDLE);
      chk("midrst_busy", busy, 0);
      chk("midrst_ready", cmd_if.cmd_ready, 1);
      chk("midrst_pwm", pwm_out, 0);
      chk("midrst_done", done, 0);
      rst_n = 1'b1;
      base = cyc + 1;
      m_cur = OW;
      pulses.delete();
      dc0 = done_count;
      repeat (400) step();
      chk("midrst_no_done", done_count - dc0, 0);
      chk("midrst_cur_w_hold", cur_w, OW);
      check_pulses("midrst_width", 0, 0, OW, OW, cyc);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
